// File: rtl/reel_spinner_if.sv
// Reel spinner bus: spin request, reel codes and status; force inputs exist only with REEL_FORCE_EN.
interface reel_spinner_if;
  logic       spin;
  logic [2:0] first;
  logic [2:0] second;
  logic [2:0] third;
  logic       spinning;
  logic       payout;
`ifdef REEL_FORCE_EN
  logic       force_en;
  logic [2:0] force_first;
  logic [2:0] force_second;
  logic [2:0] force_third;

  modport master (
    output spin, force_en, force_first, force_second, force_third,
    input  first, second, third, spinning, payout
  );
  modport slave (
    input  spin, force_en, force_first, force_second, force_third,
    output first, second, third, spinning, payout
  );
`else
  modport master (
    output spin,
    input  first, second, third, spinning, payout
  );
  modport slave (
    input  spin,
    output first, second, third, spinning, payout
  );
`endif
endinterface

// File: rtl/reel_spinner.sv
// Three-reel slot spinner: LFSR-animated reels, staggered freeze, one-clock payout pulse.
// Optional REEL_FORCE_EN adds force inputs that override the frozen reel codes.
module reel_spinner #(
  parameter int unsigned SPIN_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic           clk,
  input logic           resetn,
  reel_spinner_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SPIN  = 3'd1;
  localparam logic [2:0] STOP1 = 3'd2;
  localparam logic [2:0] STOP2 = 3'd3;
  localparam logic [2:0] PAY   = 3'd4;

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] SPIN_LAST  = 16'(SPIN_CYCLES - 1);
  localparam logic [15:0] STAG_LAST  = 16'(STAGGER_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] count_q, count_d;
  logic        spin_q;
  logic [2:0]  first_q, first_d;
  logic [2:0]  second_q, second_d;
  logic [2:0]  third_q, third_d;
  logic        spinning_q, spinning_d;
  logic        payout_q, payout_d;

  logic [2:0]  r1, r2, r3;
  logic [2:0]  frz1, frz2, frz3;

  assign r1 = lfsr_q[2:0];
  assign r2 = lfsr_q[7:5];
  assign r3 = lfsr_q[12:10];

`ifdef REEL_FORCE_EN
  assign frz1 = bus.force_en ? bus.force_first  : r1;
  assign frz2 = bus.force_en ? bus.force_second : r2;
  assign frz3 = bus.force_en ? bus.force_third  : r3;
`else
  assign frz1 = r1;
  assign frz2 = r2;
  assign frz3 = r3;
`endif

  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d    = state_q;
    count_d    = count_q + 16'd1;
    first_d    = first_q;
    second_d   = second_q;
    third_d    = third_q;
    spinning_d = spinning_q;
    payout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = count_q;
        if (bus.spin && !spin_q) begin
          state_d    = SPIN;
          spinning_d = 1'b1;
          count_d    = 16'd0;
        end
      end
      SPIN: begin
        first_d  = r1;
        second_d = r2;
        third_d  = r3;
        if (count_q == SPIN_LAST) begin
          first_d = frz1;
          state_d = STOP1;
          count_d = 16'd0;
        end
      end
      STOP1: begin
        second_d = r2;
        third_d  = r3;
        if (count_q == STAG_LAST) begin
          second_d = frz2;
          state_d  = STOP2;
          count_d  = 16'd0;
        end
      end
      STOP2: begin
        third_d = r3;
        if (count_q == STAG_LAST) begin
          third_d    = frz3;
          state_d    = PAY;
          spinning_d = 1'b0;
          count_d    = 16'd0;
        end
      end
      PAY: begin
        // First PAY clock raises the pulse, second drops it and returns to IDLE.
        count_d = count_q;
        if (!payout_q) begin
          payout_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        spinning_d = 1'b0;
        count_d    = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      count_q    <= 16'd0;
      spin_q     <= 1'b0;
      first_q    <= 3'd0;
      second_q   <= 3'd0;
      third_q    <= 3'd0;
      spinning_q <= 1'b0;
      payout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      count_q    <= count_d;
      spin_q     <= bus.spin;
      first_q    <= first_d;
      second_q   <= second_d;
      third_q    <= third_d;
      spinning_q <= spinning_d;
      payout_q   <= payout_d;
    end
  end

  assign bus.first    = first_q;
  assign bus.second   = second_q;
  assign bus.third    = third_q;
  assign bus.spinning = spinning_q;
  assign bus.payout   = payout_q;

endmodule

// File: tb/tb_reel_spinner.sv
// Directed self-checking bench for reel_spinner (SPIN_CYCLES=4, STAGGER_CYCLES=2).
module tb_reel_spinner;

  localparam int S = 4;
  localparam int T = 2;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  reel_spinner_if bus ();

  reel_spinner #(
    .SPIN_CYCLES   (S),
    .STAGGER_CYCLES(T),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent LFSR model: x^16+x^14+x^13+x^11+1, steps every clock.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic test_reset();
    resetn   = 1'b0;
    bus.spin = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.first, bus.second, bus.third, bus.spinning, bus.payout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_hold got %b%b%b %b %b want all 0", bus.first, bus.second, bus.third,
               bus.spinning, bus.payout);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({bus.first, bus.second, bus.third, bus.spinning, bus.payout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release got %b%b%b %b %b want all 0", bus.first, bus.second,
               bus.third, bus.spinning, bus.payout);
    end
  endtask

  task automatic test_spin_timing(input string tag);
    logic [2:0] e1 = 3'd0;
    logic [2:0] e2 = 3'd0;
    logic [2:0] e3 = 3'd0;
    @(negedge clk) bus.spin = 1'b1;
    @(negedge clk) bus.spin = 1'b0;
    n_tests++;
    if (bus.spinning !== 1'b1 || bus.payout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept got spinning=%b payout=%b want 1 0", tag, bus.spinning, bus.payout);
    end
    for (int k = 1; k <= 12; k++) begin
      // Model value just before edge E+k is what the DUT latches on that edge.
      if (k == S)       e1 = m_lfsr[2:0];
      if (k == S + T)   e2 = m_lfsr[7:5];
      if (k == S + 2*T) e3 = m_lfsr[12:10];
      @(negedge clk);
      n_tests++;
      if (bus.spinning !== logic'(k < S + 2*T)) begin
        n_fail++;
        $display("FAIL %s_spinning k=%0d got %b want %b", tag, k, bus.spinning,
                 logic'(k < S + 2*T));
      end
      n_tests++;
      if (bus.payout !== logic'(k == S + 2*T + 1)) begin
        n_fail++;
        $display("FAIL %s_payout k=%0d got %b want %b", tag, k, bus.payout,
                 logic'(k == S + 2*T + 1));
      end
      if (k >= S) begin
        n_tests++;
        if (bus.first !== e1) begin
          n_fail++;
          $display("FAIL %s_first k=%0d got %0d want %0d", tag, k, bus.first, e1);
        end
      end
      if (k >= S + T) begin
        n_tests++;
        if (bus.second !== e2) begin
          n_fail++;
          $display("FAIL %s_second k=%0d got %0d want %0d", tag, k, bus.second, e2);
        end
      end
      if (k >= S + 2*T) begin
        n_tests++;
        if (bus.third !== e3) begin
          n_fail++;
          $display("FAIL %s_third k=%0d got %0d want %0d", tag, k, bus.third, e3);
        end
      end
    end
  endtask

`ifdef REEL_FORCE_EN
  task automatic force_spin(input logic [2:0] f1, input logic [2:0] f2, input logic [2:0] f3);
    int w = 0;
    bus.force_en     = 1'b1;
    bus.force_first  = f1;
    bus.force_second = f2;
    bus.force_third  = f3;
    @(negedge clk) bus.spin = 1'b1;
    @(negedge clk) bus.spin = 1'b0;
    while (bus.payout !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (bus.payout !== 1'b1 || {bus.first, bus.second, bus.third} !== {f1, f2, f3}) begin
      n_fail++;
      $display("FAIL force payout=%b got %0d/%0d/%0d want %0d/%0d/%0d", bus.payout, bus.first,
               bus.second, bus.third, f1, f2, f3);
    end
    bus.force_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_force();
`ifdef REEL_FORCE_EN
    force_spin(3'b111, 3'b111, 3'b111);
    force_spin(3'b011, 3'b011, 3'b000);
`endif
  endtask

  task automatic test_held_spin();
    int pays    = 0;
    int overlap = 0;
    bus.spin = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.payout) pays++;
      if (bus.payout && bus.spinning) overlap++;
    end
    bus.spin = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.payout) pays++;
    end
    n_tests++;
    if (pays != 1) begin
      n_fail++;
      $display("FAIL held_spin payouts got %0d want 1", pays);
    end
    pays = 0;
    @(negedge clk) bus.spin = 1'b1;
    @(negedge clk) bus.spin = 1'b0;
    repeat (2) @(negedge clk);
    bus.spin = 1'b1;  // second rising edge sampled at E+3
    @(negedge clk) bus.spin = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.payout) pays++;
      if (bus.payout && bus.spinning) overlap++;
    end
    n_tests++;
    if (pays != 1) begin
      n_fail++;
      $display("FAIL midspin_edge payouts got %0d want 1", pays);
    end
    n_tests++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL payout_spinning_overlap got %0d want 0", overlap);
    end
  endtask

  task automatic test_reset_abort();
    int pays = 0;
    int spins = 0;
    @(negedge clk) bus.spin = 1'b1;
    @(negedge clk) bus.spin = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({bus.first, bus.second, bus.third, bus.spinning, bus.payout} !== 11'd0) begin
      n_fail++;
      $display("FAIL abort_async got %b%b%b %b %b want all 0", bus.first, bus.second, bus.third,
               bus.spinning, bus.payout);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.payout) pays++;
      if (bus.spinning) spins++;
    end
    n_tests++;
    if (pays != 0 || spins != 0) begin
      n_fail++;
      $display("FAIL abort_no_payout got payouts=%0d spinning_cycles=%0d want 0 0", pays, spins);
    end
    test_spin_timing("post_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] c1 = 8'd0;
    logic [7:0] c2 = 8'd0;
    logic [7:0] c3 = 8'd0;
    int pays     = 0;
    int timeouts = 0;
    int zeros    = 0;
    for (int n = 0; n < 100; n++) begin
      int w = 0;
      @(negedge clk) bus.spin = 1'b1;
      @(negedge clk) bus.spin = 1'b0;
      while (bus.payout !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
        if (dut.lfsr_q == 16'd0) zeros++;
      end
      if (bus.payout === 1'b1) begin
        pays++;
        c1[bus.first]  = 1'b1;
        c2[bus.second] = 1'b1;
        c3[bus.third]  = 1'b1;
      end else begin
        timeouts++;
      end
    end
    n_tests++;
    if (pays != 100 || timeouts != 0) begin
      n_fail++;
      $display("FAIL b2b_payouts got %0d (timeouts %0d) want 100", pays, timeouts);
    end
    n_tests++;
    if (c1 !== 8'hFF || c2 !== 8'hFF || c3 !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_coverage got %h/%h/%h want ff/ff/ff", c1, c2, c3);
    end
    n_tests++;
    if (zeros != 0) begin
      n_fail++;
      $display("FAIL b2b_lfsr_zero got %0d zero cycles want 0", zeros);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.spin = 1'b0;
`ifdef REEL_FORCE_EN
    bus.force_en     = 1'b0;
    bus.force_first  = 3'd0;
    bus.force_second = 3'd0;
    bus.force_third  = 3'd0;
`endif
    test_reset();
    test_spin_timing("basic");
    test_force();
    test_held_spin();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
